// File: rtl/booth_seq_mult_pkg.sv
// Shared constants and types for the sequential Booth multiplier.
package mult_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Booth codes formed from {Q[0], q_m1}
    localparam logic [1:0] BOOTH_NOP0 = 2'b00;
    localparam logic [1:0] BOOTH_ADD  = 2'b01;
    localparam logic [1:0] BOOTH_SUB  = 2'b10;
    localparam logic [1:0] BOOTH_NOP1 = 2'b11;

endpackage

// File: rtl/booth_operand_sel.sv
// Booth step operand select: maps the two-bit Booth code to the adder
// B operand and carry-in (+M, -M as ~M with cin=1, or nothing).
module booth_operand_sel
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [1:0]       code,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin
);

    // Decode the Booth pair into an add, a subtract or a pass-through.
    always_comb begin
        add_b   = '0;
        add_cin = 1'b0;
        case (code)
            BOOTH_ADD: begin
                add_b   = m;
                add_cin = 1'b0;
            end
            BOOTH_SUB: begin
                add_b   = ~m;
                add_cin = 1'b1;
            end
            default: begin
                add_b   = '0;
                add_cin = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential signed radix-2 Booth multiplier, one step per clock, using an
// external WIDTH-bit adder through the add_* ports.
// Optional: define MULT_OVF_EN to add the prod_ovf output, which flags a
// product that does not fit in a signed WIDTH-bit value.
module booth_seq_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_cout
`ifdef MULT_OVF_EN
    ,
    output logic               prod_ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             state, state_nxt;
    logic [WIDTH-1:0]   acc, q, m;
    logic               q_m1;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   sel_b;
    logic               sel_cin;
    logic               sum_sign;

    booth_operand_sel #(.WIDTH(WIDTH)) u_sel (
        .code    ({q[0], q_m1}),
        .m       (m),
        .add_b   (sel_b),
        .add_cin (sel_cin)
    );

    // True sign of the (WIDTH+1)-bit step result; shifting this in instead of
    // add_sum's MSB keeps the M = most-negative case correct.
    assign sum_sign = add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_cout;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, handshake outputs and adder operands; adder idles at 0 outside RUN.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_prod  = '0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                add_a   = acc;
                add_b   = sel_b;
                add_cin = sel_cin;
                if (cnt == CNT_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                out_prod  = {acc, q};
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then one Booth shift per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            q    <= '0;
            q_m1 <= 1'b0;
            m    <= '0;
            cnt  <= '0;
        end else if (state == IDLE && in_valid) begin
            m    <= in_a;
            q    <= in_b;
            acc  <= '0;
            q_m1 <= 1'b0;
            cnt  <= CNT_W'(WIDTH);
        end else if (state == RUN) begin
            {acc, q, q_m1} <= {sum_sign, add_sum, q};
            cnt            <= cnt - CNT_W'(1);
        end
    end

`ifdef MULT_OVF_EN
    // Overflow when the upper WIDTH+1 bits are not a pure sign extension.
    always_comb begin
        prod_ovf = 1'b0;
        if (state == DONE)
            prod_ovf = !((&out_prod[2*WIDTH-1:WIDTH-1]) || !(|out_prod[2*WIDTH-1:WIDTH-1]));
    end
`endif

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed testbench for booth_seq_mult; models the external adder.
module tb_booth_seq_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_prod;
    logic [31:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout;
`ifdef MULT_OVF_EN
    logic        prod_ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Behavioural model of the 32-bit adder sitting next to the multiplier.
    always_comb {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    booth_seq_mult #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
`ifdef MULT_OVF_EN
        , .prod_ovf(prod_ovf)
`endif
    );

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Edges from accept until out_valid; 999 if it never arrives.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        if (!out_valid) cyc = 999;
    endtask

    task automatic retire();
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_prod !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_prod=%h, want 1 0 0", in_ready, out_valid, out_prod);
        end
        n_tests++;
        if (add_a !== 32'd0 || add_b !== 32'd0 || add_cin !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_adder: add_a=%h add_b=%h add_cin=%b, want 0", add_a, add_b, add_cin);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_mult(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] exp, input logic exp_ovf);
        int cyc;
        start_op(a, b);
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy: in_ready=%b, want 0", name, in_ready);
        end
        wait_done(cyc);
        n_tests++;
        if (cyc !== 32) begin
            n_fail++;
            $display("FAIL %s_latency: %0d edges, want 32", name, cyc);
        end
        n_tests++;
        if (out_prod !== exp) begin
            n_fail++;
            $display("FAIL %s_prod: got %h, want %h", name, out_prod, exp);
        end
`ifdef MULT_OVF_EN
        n_tests++;
        if (prod_ovf !== exp_ovf) begin
            n_fail++;
            $display("FAIL %s_ovf: got %b, want %b", name, prod_ovf, exp_ovf);
        end
`else
        if (exp_ovf) begin end
`endif
        retire();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_retire: out_valid=%b in_ready=%b, want 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_hold();
        int cyc;
        start_op(32'd12, 32'd12);
        wait_done(cyc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            in_a = 32'd1; in_b = 32'd1;
            @(posedge clk);
            #1;
            n_tests++;
            if (out_valid !== 1'b1 || out_prod !== 64'h90 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d: out_valid=%b out_prod=%h in_ready=%b, want 1 90 0", i, out_valid, out_prod, in_ready);
            end
        end
        @(negedge clk) in_valid = 1'b0;
        retire();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_retire: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || add_a !== 32'd0 || add_b !== 32'd0) begin
            n_fail++;
            $display("FAIL hold_no_accept: in_ready=%b add_a=%h add_b=%h, want 1 0 0", in_ready, add_a, add_b);
        end
    endtask

    task automatic test_mid_reset();
        start_op(32'd9, 32'd9);
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_running: in_ready=%b, want 0", in_ready);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_prod !== 64'd0 ||
            add_a !== 32'd0 || add_b !== 32'd0 || add_cin !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: in_ready=%b out_valid=%b out_prod=%h add_a=%h add_b=%h add_cin=%b, want reset values",
                     in_ready, out_valid, out_prod, add_a, add_b, add_cin);
        end
        @(negedge clk) rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_release: in_ready=%b, want 1", in_ready);
        end
        test_mult("after_rst_2x2", 32'd2, 32'd2, 64'd4, 1'b0);
    endtask

    task automatic test_back_to_back();
        int edge_n;
        int seen[2];
        int nseen;
        edge_n = 0;
        nseen  = 0;
        @(negedge clk);
        in_a = 32'd3; in_b = 32'd5; in_valid = 1'b1; out_ready = 1'b1;
        while (nseen < 2 && edge_n < 200) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                n_tests++;
                if (out_prod !== 64'd15) begin
                    n_fail++;
                    $display("FAIL b2b_prod_%0d: got %h, want f", nseen, out_prod);
                end
                seen[nseen] = edge_n;
                nseen++;
            end
            edge_n++;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b0;
        n_tests++;
        if (nseen != 2 || seen[0] != 32 || seen[1] - seen[0] != 34) begin
            n_fail++;
            $display("FAIL b2b_spacing: results=%0d first=%0d gap=%0d, want 2 32 34",
                     nseen, seen[0], seen[1] - seen[0]);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_mult("7x3",       32'd7,        32'd3,        64'h0000_0000_0000_0015, 1'b0);
        test_mult("m5x6",      32'hFFFF_FFFB, 32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFE2, 1'b0);
        test_mult("min_x_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1);
        test_mult("min_x_m1",  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1);
        test_hold();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
